// File: rtl/seq_signed_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;
  localparam int DIV_DW_N  = 16;
  localparam int DIV_DW_D  = 8;
  localparam int DIV_CNT_W = 5;

  // Quotient returned for a zero divisor, chosen by dividend sign
  localparam logic [DIV_DW_N-1:0] DIV_Q_POS_SAT = 16'h7FFF;
  localparam logic [DIV_DW_N-1:0] DIV_Q_NEG_SAT = 16'h8000;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} div_state_t;
endpackage

// File: rtl/seq_signed_div_if.sv
// Start/done handshake and operand/result bundle for seq_signed_div.
interface seq_signed_div_if #(parameter int DW_N = 16, parameter int DW_D = 8);
  logic                   start;
  logic signed [DW_N-1:0] dividend;
  logic signed [DW_D-1:0] divisor;
  logic                   busy;
  logic                   done;
  logic signed [DW_N-1:0] quotient;
  logic signed [DW_D-1:0] remainder;
  logic                   div_by_zero;
  logic                   ovf;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero, ovf);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero, ovf);
endinterface

// File: rtl/seq_signed_div_step.sv
// One restoring-division step on unsigned magnitudes.
module div_step #(parameter int DW_D = 8) (
  input  logic [DW_D-1:0] rem_i,
  input  logic            bit_i,
  input  logic [DW_D-1:0] dmag,
  output logic [DW_D-1:0] rem_o,
  output logic            q_o
);
  // Shifted partial remainder needs one extra bit before the trial subtract
  logic [DW_D:0] sh;

  assign sh    = {rem_i, bit_i};
  assign q_o   = (sh >= {1'b0, dmag});
  assign rem_o = q_o ? DW_D'(sh - {1'b0, dmag}) : sh[DW_D-1:0];
endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider, one quotient bit per clock, C truncation semantics.
// Build option: SEQ_DIV_ZERO_FAST_EN returns zero-divide results straight from IDLE.
module seq_signed_div import div_pkg::*; #(
  parameter int DW_N = DIV_DW_N,
  parameter int DW_D = DIV_DW_D
) (
  input logic             clk,
  input logic             rst_n,
  seq_signed_div_if.slave bus
);
  div_state_t            state;
  logic [DIV_CNT_W-1:0]  cnt;
  logic [DW_N-1:0]       nmag;   // dividend magnitude, shifted out as quotient bits shift in
  logic [DW_D-1:0]       dmag, rem, rem_nxt;
  logic                  sn, sd, qbit, zero;
  logic                  busy_r, done_r, dbz_r, ovf_r;
  logic [DW_N-1:0]       q_r;
  logic [DW_D-1:0]       r_r;
  logic [DW_N-1:0]       a_abs;
  logic [DW_D-1:0]       b_abs;

  assign a_abs = bus.dividend[DW_N-1] ? DW_N'(0) - bus.dividend : bus.dividend;
  assign b_abs = bus.divisor[DW_D-1]  ? DW_D'(0) - bus.divisor  : bus.divisor;
  assign zero  = (dmag == '0);

  div_step #(.DW_D(DW_D)) u_step (
    .rem_i(rem), .bit_i(nmag[DW_N-1]), .dmag(dmag), .rem_o(rem_nxt), .q_o(qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      nmag   <= '0;
      dmag   <= '0;
      rem    <= '0;
      sn     <= 1'b0;
      sd     <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      ovf_r  <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        CALC: begin
          rem  <= rem_nxt;
          nmag <= {nmag[DW_N-2:0], qbit};
          cnt  <= cnt + 1'b1;
          if (cnt == DIV_CNT_W'(DW_N-1)) state <= SIGN;
        end
        SIGN: begin
          q_r    <= zero ? (sn ? DIV_Q_NEG_SAT : DIV_Q_POS_SAT)
                         : ((sn ^ sd) ? DW_N'(0) - nmag : nmag);
          r_r    <= zero ? '0 : (sn ? DW_D'(0) - rem : rem);
          dbz_r  <= zero;
          // Only -2^(N-1) / -1 yields a 2^(N-1) quotient magnitude with like signs
          ovf_r  <= !zero && sn && sd && (nmag == {1'b1, {(DW_N-1){1'b0}}});
          done_r <= 1'b1;
          state  <= DONE;
        end
        default: begin
          // DONE falls through to IDLE in the same edge, so a start here is taken
          // and back-to-back divides run every 18 cycles.
          busy_r <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            busy_r <= 1'b1;
            sn     <= bus.dividend[DW_N-1];
            sd     <= bus.divisor[DW_D-1];
            nmag   <= a_abs;
            dmag   <= b_abs;
            cnt    <= '0;
            rem    <= '0;
            state  <= CALC;
`ifdef SEQ_DIV_ZERO_FAST_EN
            if (bus.divisor == '0) begin
              q_r    <= bus.dividend[DW_N-1] ? DIV_Q_NEG_SAT : DIV_Q_POS_SAT;
              r_r    <= '0;
              dbz_r  <= 1'b1;
              ovf_r  <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end
`endif
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.ovf         = ovf_r;
endmodule

// File: tb/tb_seq_signed_div.sv
// Scoreboard bench for seq_signed_div: directed vectors, done-cycle latency checks.
module tb_seq_signed_div;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_signed_div_if #(.DW_N(16), .DW_D(8)) bus();
  seq_signed_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic signed [15:0] q;
    logic signed [7:0]  r;
    logic               dbz;
    logic               ovf;
    int                 due;
    int                 id;
  } exp_t;

`ifdef SEQ_DIV_ZERO_FAST_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 17;
`endif

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest expected result and its due edge
  always @(negedge clk) begin
    if (bus.done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done at edge %0d with no pending vector", cyc);
      end else begin
        e = sb.pop_front();
        if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz ||
            bus.ovf !== e.ovf || cyc != e.due) begin
          n_fail++;
          $display("FAIL vec%0d: got q=%0d r=%0d dbz=%b ovf=%b edge=%0d, expected q=%0d r=%0d dbz=%b ovf=%b edge=%0d",
                   e.id, bus.quotient, bus.remainder, bus.div_by_zero, bus.ovf, cyc,
                   e.q, e.r, e.dbz, e.ovf, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, int'(bus.busy), 0);
    chk({nm, "_done"}, int'(bus.done), 0);
    chk({nm, "_q"},    int'(bus.quotient), 0);
    chk({nm, "_r"},    int'(bus.remainder), 0);
    chk({nm, "_dbz"},  int'(bus.div_by_zero), 0);
    chk({nm, "_ovf"},  int'(bus.ovf), 0);
  endtask

  // Drives start for one edge; returns the accepting edge number
  task automatic issue(input int id, input logic signed [15:0] a, input logic signed [7:0] b,
                       input logic signed [15:0] eq, input logic signed [7:0] er,
                       input logic edz, input logic eov, output int k);
    exp_t x;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = cyc;
    x.q = eq; x.r = er; x.dbz = edz; x.ovf = eov; x.id = id;
    x.due = k + ((b == 8'sd0) ? ZLAT : 17);
    sb.push_back(x);
    chk("busy_after_accept", int'(bus.busy), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    chk("idle_within_bound", int'(bus.busy), 0);
  endtask

  task automatic run(input int id, input logic signed [15:0] a, input logic signed [7:0] b,
                     input logic signed [15:0] eq, input logic signed [7:0] er,
                     input logic edz, input logic eov);
    int k;
    issue(id, a, b, eq, er, edz, eov, k);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(1,    100,    7,     14,    2, 1'b0, 1'b0);
    run(2,   -100,    7,    -14,   -2, 1'b0, 1'b0);
    run(3,    100,   -7,    -14,    2, 1'b0, 1'b0);
    run(4,   -100,   -7,     14,   -2, 1'b0, 1'b0);
    run(5,   1000, -128,     -7,  104, 1'b0, 1'b0);
    run(6, -32768,   -1, -32768,    0, 1'b0, 1'b1);
    run(7,      5,    0,  32767,    0, 1'b1, 1'b0);
    run(8,     -5,    0, -32768,    0, 1'b1, 1'b0);
    run(9,  32767,  127,    258,    1, 1'b0, 1'b0);
    run(10,-32768,  127,   -258,   -2, 1'b0, 1'b0);
    run(11,-32768, -128,    256,    0, 1'b0, 1'b0);
    run(12,     0,    5,      0,    0, 1'b0, 1'b0);
    run(13,     7,  100,      0,    7, 1'b0, 1'b0);

    // start while busy is dropped; start on the DONE cycle is taken
    issue(20, 100, 7, 14, 2, 1'b0, 1'b0, k);
    while (cyc < k + 4) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'sd50;
    bus.divisor = 8'sd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_through_ignored_start", int'(bus.busy), 1);
    while (cyc < k + 17) @(negedge clk);
    chk("done_at_k17", int'(bus.done), 1);
    issue(21, -1000, 9, -111, -1, 1'b0, 1'b0, k2);
    chk("b2b_accept_edge", k2 - k, 18);
    wait_idle();

    // asynchronous reset mid-operation discards the divide in flight
    issue(30, 100, 7, 14, 2, 1'b0, 1'b0, k);
    while (cyc < k + 7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midop_reset");
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(31, 9, 3, 3, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
